forwarding_hazard_unit: RTL and testbench
=========================================

// Module: forwarding_hazard_unit
// PURPOSE
//  Generates the 2-bit selectors for the EX-stage operand forwarding muxes (3-to-1,
//  Selector 00/01/10) and the load-use stall/bubble controls of the 5-stage pipeline.
//  Keeps its own shadow copy of the ID/EX, EX/MEM and MEM/WB register-usage fields, so
//  the datapath supplies only decode-stage information. Sits between decode and EX.
// PARAMETERS
//  ADDR_W  5   register-file address width
//  CNT_W   16  width of the saturating stall counter
// PORTS
//  clk          in   1       pipeline clock, all state updates on rising edge
//  reset        in   1       synchronous, active-high
//  ID_Valid     in   1       decode stage holds a real instruction
//  ID_Rs        in   ADDR_W  rs source of the instruction in decode
//  ID_Rt        in   ADDR_W  rt source of the instruction in decode
//  ID_UsesRt    in   1       rt is read as a source (R-type, store, branch)
//  ID_WriteReg  in   ADDR_W  resolved destination register of the decode instruction
//  ID_RegWrite  in   1       decode instruction writes the register file
//  ID_MemRead   in   1       decode instruction is a load
//  Flush        in   1       branch/jump taken: kill the instruction in decode
//  ForwardA     out  2       selector for EX operand A mux (rs)
//  ForwardB     out  2       selector for EX operand B mux (rt)
//  Stall        out  1       hold PC and IF/ID this cycle
//  Bubble       out  1       zero ID/EX control fields at next edge
//  StallCount   out  CNT_W   number of stall cycles since reset, saturating
// BEHAVIOUR
//  - Shadow stages EX, MEM, WB: {valid, rs, rt, wr, regwrite, memread} each.
//  - Every edge (no reset): WB<=MEM; MEM<=EX; EX<= Bubble|!ID_Valid ? invalid : ID fields.
//    Stall never freezes EX/MEM/WB; it only inserts an invalid entry into EX.
//  - Load-use raw hazard: ID_Valid & EX.valid & EX.memread & EX.wr!=0 &
//    (EX.wr==ID_Rs | (ID_UsesRt & EX.wr==ID_Rt)).
//  - Stall  = hazard & !Flush (flush wins; killed instruction needs no stall).
//  - Bubble = Stall | Flush. Both combinational, same cycle as the condition.
//  - ForwardA (ForwardB identical, using EX.rt):
//      10 if MEM.valid & MEM.regwrite & MEM.wr!=0 & MEM.wr==EX.rs  (ALU result, EX/MEM)
//      01 else if WB.valid & WB.regwrite & WB.wr!=0 & WB.wr==EX.rs (write-back data)
//      00 otherwise (register-file value). Youngest producer has priority.
//    11 is never driven (mux leaves it undefined). Forward outputs are functions of
//    shadow registers only: no combinational path from ID_* to ForwardA/B.
//  - Register 0 is never a forwarding or stall source.
//  - StallCount +1 on each cycle with Stall=1; holds at 2^CNT_W-1.
//  - Reset (any time, including mid-stall): all shadow valid=0, StallCount=0 at the
//    edge; ForwardA/B=00 the following cycle; Stall/Bubble follow only Flush and ID
//    inputs against the now-empty EX stage (i.e. Stall=0).
//  - Latency: ID info affects ForwardA/B one cycle later (when in EX).
// TESTING
//  1. add $3 then add rs=$3 back-to-back -> ForwardA=10 while consumer in EX; with one
//     independent instr between -> ForwardA=01; two between -> 00.
//  2. lw $4 then add rt=$4 (UsesRt=1) -> Stall=1,Bubble=1 one cycle, StallCount=1;
//     consumer reaches EX one cycle later with ForwardB=01.
//  3. lw $4 then instr with UsesRt=0, rt=$4 -> no stall; destination $0 with
//     RegWrite=1 -> Forward 00, no stall.
//  4. MEM and WB both write $7, EX reads $7 on rs and rt -> ForwardA=ForwardB=10.
//  5. Load-use hazard with Flush=1 same cycle -> Stall=0, Bubble=1, count unchanged;
//     bubble never selected by forwarding (Forward 00 two cycles later).
//  6. reset asserted during a stall with CNT_W=2 after 5 stalls (count held 3) ->
//     next cycle ForwardA/B=00, Stall=0, StallCount=0.

Source files
------------

// File: rtl/forwarding_hazard_unit.sv
// EX-stage operand forwarding selectors and load-use stall/bubble generation for a
// 5-stage pipeline, driven from decode-stage fields and internal shadow stage copies.
module forwarding_hazard_unit #(
    parameter int ADDR_W = 5,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              ID_Valid,
    input  logic [ADDR_W-1:0] ID_Rs,
    input  logic [ADDR_W-1:0] ID_Rt,
    input  logic              ID_UsesRt,
    input  logic [ADDR_W-1:0] ID_WriteReg,
    input  logic              ID_RegWrite,
    input  logic              ID_MemRead,
    input  logic              Flush,
    output logic [1:0]        ForwardA,
    output logic [1:0]        ForwardB,
    output logic              Stall,
    output logic              Bubble,
    output logic [CNT_W-1:0]  StallCount
);

    typedef struct packed {
        logic              valid;
        logic [ADDR_W-1:0] rs;
        logic [ADDR_W-1:0] rt;
        logic [ADDR_W-1:0] wr;
        logic              regwrite;
        logic              memread;
    } ex_stage_t;

    // Past EX only the producer side of an instruction is ever consulted.
    typedef struct packed {
        logic              valid;
        logic [ADDR_W-1:0] wr;
        logic              regwrite;
    } prod_stage_t;

    ex_stage_t         r_ex;
    prod_stage_t       r_mem;
    prod_stage_t       r_wb;
    ex_stage_t         w_ex_next;
    logic [CNT_W-1:0]  r_stall_count;
    logic              w_hazard;
    logic              w_stall;
    logic              w_bubble;
    logic [ADDR_W-1:0] w_ex_src [2];
    logic [1:0]        w_fwd    [2];

    function automatic logic producer_hit(input prod_stage_t s, input logic [ADDR_W-1:0] src);
        return s.valid && s.regwrite && (s.wr != '0) && (s.wr == src);
    endfunction

    assign w_hazard = ID_Valid && r_ex.valid && r_ex.memread && (r_ex.wr != '0) &&
                      ((r_ex.wr == ID_Rs) || (ID_UsesRt && (r_ex.wr == ID_Rt)));
    assign w_stall  = w_hazard && !Flush;
    assign w_bubble = w_stall || Flush;

    // Killed or empty decode slots enter EX fully zeroed so they can never match.
    always_comb begin
        w_ex_next = '0;
        if (ID_Valid && !w_bubble) begin
            w_ex_next.valid    = 1'b1;
            w_ex_next.rs       = ID_Rs;
            w_ex_next.rt       = ID_Rt;
            w_ex_next.wr       = ID_WriteReg;
            w_ex_next.regwrite = ID_RegWrite;
            w_ex_next.memread  = ID_MemRead;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_ex          <= '0;
            r_mem         <= '0;
            r_wb          <= '0;
            r_stall_count <= '0;
        end else begin
            r_ex           <= w_ex_next;
            r_mem.valid    <= r_ex.valid;
            r_mem.wr       <= r_ex.wr;
            r_mem.regwrite <= r_ex.regwrite;
            r_wb           <= r_mem;
            if (w_stall && (r_stall_count != '1)) begin
                r_stall_count <= r_stall_count + CNT_W'(1);
            end
        end
    end

    assign w_ex_src[0] = r_ex.rs;
    assign w_ex_src[1] = r_ex.rt;

    // Youngest producer (EX/MEM) wins over write-back.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_fwd
            assign w_fwd[gi] = producer_hit(r_mem, w_ex_src[gi]) ? 2'b10 :
                               producer_hit(r_wb,  w_ex_src[gi]) ? 2'b01 : 2'b00;
        end
    endgenerate

    assign ForwardA   = w_fwd[0];
    assign ForwardB   = w_fwd[1];
    assign Stall      = w_stall;
    assign Bubble     = w_bubble;
    assign StallCount = r_stall_count;

endmodule

// File: tb/tb_forwarding_hazard_unit.sv
// Self-checking bench for forwarding_hazard_unit: directed vector table, reset-mid-stall
// sequence and randomized traffic against an instruction-history reference model.
module tb_forwarding_hazard_unit;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset, ID_Valid, ID_UsesRt, ID_RegWrite, ID_MemRead, Flush;
    logic [4:0] ID_Rs, ID_Rt, ID_WriteReg;
    logic [1:0] fa, fb, fa2, fb2;
    logic       st, bu, st2, bu2;
    logic [15:0] cnt;
    logic [1:0]  cnt2;

    forwarding_hazard_unit dut (
        .clk(clk), .reset(reset), .ID_Valid(ID_Valid), .ID_Rs(ID_Rs), .ID_Rt(ID_Rt),
        .ID_UsesRt(ID_UsesRt), .ID_WriteReg(ID_WriteReg), .ID_RegWrite(ID_RegWrite),
        .ID_MemRead(ID_MemRead), .Flush(Flush), .ForwardA(fa), .ForwardB(fb),
        .Stall(st), .Bubble(bu), .StallCount(cnt)
    );

    forwarding_hazard_unit #(.ADDR_W(5), .CNT_W(2)) dut2 (
        .clk(clk), .reset(reset), .ID_Valid(ID_Valid), .ID_Rs(ID_Rs), .ID_Rt(ID_Rt),
        .ID_UsesRt(ID_UsesRt), .ID_WriteReg(ID_WriteReg), .ID_RegWrite(ID_RegWrite),
        .ID_MemRead(ID_MemRead), .Flush(Flush), .ForwardA(fa2), .ForwardB(fb2),
        .Stall(st2), .Bubble(bu2), .StallCount(cnt2)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Reference model: history of what entered EX, newest first (0=EX, 1=MEM, 2=WB).
    typedef struct {
        bit v;
        int rs, rt, wr;
        bit rw, mr;
    } ent_t;

    ent_t pipe_q[$];
    int   m_cnt;
    bit   m_stall, m_bubble;

    function automatic ent_t empty_ent();
        ent_t e;
        e.v = 0; e.rs = 0; e.rt = 0; e.wr = 0; e.rw = 0; e.mr = 0;
        return e;
    endfunction

    task automatic model_reset();
        pipe_q.delete();
        for (int i = 0; i < 3; i++) pipe_q.push_back(empty_ent());
        m_cnt = 0;
    endtask

    // Selector = 3 - age of the youngest older instruction writing src (age 1 -> 2, age 2 -> 1).
    function automatic int m_fwd(input int src);
        for (int age = 1; age <= 2; age++) begin
            if (pipe_q[age].v && pipe_q[age].rw && pipe_q[age].wr != 0 && pipe_q[age].wr == src)
                return 3 - age;
        end
        return 0;
    endfunction

    task automatic drive(input logic r, input logic v, input int rs, input int rt, input logic ut,
                         input int wr, input logic rw, input logic mr, input logic fl);
        reset = r; ID_Valid = v; ID_Rs = 5'(rs); ID_Rt = 5'(rt); ID_UsesRt = ut;
        ID_WriteReg = 5'(wr); ID_RegWrite = rw; ID_MemRead = mr; Flush = fl;
        @(negedge clk);
    endtask

    task automatic model_check(input string tag);
        ent_t ex;
        int   efa, efb, ecnt, ecnt2;
        ex = pipe_q[0];
        m_stall  = ID_Valid && ex.v && ex.mr && ex.wr != 0 &&
                   (ex.wr == int'(ID_Rs) || (ID_UsesRt && ex.wr == int'(ID_Rt))) && !Flush;
        m_bubble = m_stall || Flush;
        efa   = m_fwd(ex.rs);
        efb   = m_fwd(ex.rt);
        ecnt  = (m_cnt > 65535) ? 65535 : m_cnt;
        ecnt2 = (m_cnt > 3) ? 3 : m_cnt;
        chk({tag, " ForwardA"}, fa, efa);
        chk({tag, " ForwardB"}, fb, efb);
        chk({tag, " Stall"}, st, m_stall);
        chk({tag, " Bubble"}, bu, m_bubble);
        chk({tag, " StallCount"}, cnt, ecnt);
        chk({tag, " ForwardA(w2)"}, fa2, efa);
        chk({tag, " ForwardB(w2)"}, fb2, efb);
        chk({tag, " Stall(w2)"}, st2, m_stall);
        chk({tag, " Bubble(w2)"}, bu2, m_bubble);
        chk({tag, " StallCount(w2)"}, cnt2, ecnt2);
        $display("%s: rst=%0b v=%0b rs=%0d rt=%0d wr=%0d fl=%0b -> fa=%0d fb=%0d stall=%0b bubble=%0b cnt=%0d cnt2=%0d",
                 tag, reset, ID_Valid, ID_Rs, ID_Rt, ID_WriteReg, Flush, fa, fb, st, bu, cnt, cnt2);
    endtask

    task automatic advance();
        ent_t e;
        @(posedge clk);
        if (reset) begin
            model_reset();
        end else begin
            e = empty_ent();
            if (ID_Valid && !m_bubble) begin
                e.v = 1; e.rs = ID_Rs; e.rt = ID_Rt; e.wr = ID_WriteReg;
                e.rw = ID_RegWrite; e.mr = ID_MemRead;
            end
            pipe_q.push_front(e);
            void'(pipe_q.pop_back());
            if (m_stall) m_cnt++;
        end
        #1;
    endtask

    typedef struct {
        logic v; int rs, rt; logic ut; int wr; logic rw, mr, fl;
        logic [1:0] fa, fb; logic st, bu; int cnt;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(input logic v, input int rs, input int rt, input logic ut,
                                input int wr, input logic rw, input logic mr, input logic fl,
                                input logic [1:0] efa, input logic [1:0] efb,
                                input logic est, input logic ebu, input int ecnt);
        vec_t t;
        t.v = v; t.rs = rs; t.rt = rt; t.ut = ut; t.wr = wr; t.rw = rw; t.mr = mr; t.fl = fl;
        t.fa = efa; t.fb = efb; t.st = est; t.bu = ebu; t.cnt = ecnt;
        return t;
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        //                  v  rs  rt ut  wr rw mr fl  fa fb st bu cnt
        // ALU producer -> consumer at distance 1, 2, 3
        tbl.push_back(mk(1,  1,  2, 1,  3, 1, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(1,  3,  5, 1,  6, 1, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0,  0,  0, 0,  0, 0, 0, 0, 2, 0, 0, 0, 0));
        tbl.push_back(mk(1,  1,  2, 1,  3, 1, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(1,  8,  9, 1, 10, 1, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(1,  3,  0, 0, 11, 1, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0,  0,  0, 0,  0, 0, 0, 0, 1, 0, 0, 0, 0));
        tbl.push_back(mk(1,  1,  2, 1,  3, 1, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(1,  8,  9, 1, 10, 1, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(1, 12, 13, 1, 14, 1, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(1,  3,  0, 0, 15, 1, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0,  0,  0, 0,  0, 0, 0, 0, 0, 0, 0, 0, 0));
        // load-use on rt: one stall, then write-back forwarding
        tbl.push_back(mk(1,  1,  0, 0,  4, 1, 1, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(1,  5,  4, 1, 16, 1, 0, 0, 0, 0, 1, 1, 0));
        tbl.push_back(mk(1,  5,  4, 1, 16, 1, 0, 0, 0, 0, 0, 0, 1));
        tbl.push_back(mk(0,  0,  0, 0,  0, 0, 0, 0, 0, 1, 0, 0, 1));
        // rt not used: no stall; load into $0: no stall, no forwarding
        tbl.push_back(mk(1,  1,  0, 0,  4, 1, 1, 0, 0, 0, 0, 0, 1));
        tbl.push_back(mk(1,  6,  4, 0, 17, 1, 0, 0, 0, 0, 0, 0, 1));
        tbl.push_back(mk(1,  1,  2, 1,  0, 1, 1, 0, 0, 2, 0, 0, 1));
        tbl.push_back(mk(1,  0,  0, 1, 18, 1, 0, 0, 0, 0, 0, 0, 1));
        tbl.push_back(mk(0,  0,  0, 0,  0, 0, 0, 0, 0, 0, 0, 0, 1));
        // MEM and WB both write $7: youngest wins on both operands
        tbl.push_back(mk(1,  1,  2, 1,  7, 1, 0, 0, 0, 0, 0, 0, 1));
        tbl.push_back(mk(1,  8,  9, 1,  7, 1, 0, 0, 0, 0, 0, 0, 1));
        tbl.push_back(mk(1,  7,  7, 1, 19, 1, 0, 0, 0, 0, 0, 0, 1));
        tbl.push_back(mk(0,  0,  0, 0,  0, 0, 0, 0, 2, 2, 0, 0, 1));
        // load-use coinciding with flush: bubble only, killed instruction never forwards
        tbl.push_back(mk(1,  1,  0, 0,  4, 1, 1, 0, 0, 0, 0, 0, 1));
        tbl.push_back(mk(1,  4,  0, 0, 20, 1, 0, 1, 0, 0, 0, 1, 1));
        tbl.push_back(mk(1,  4,  0, 0, 21, 1, 0, 0, 0, 0, 0, 0, 1));
        tbl.push_back(mk(1, 20, 20, 1, 22, 1, 0, 0, 1, 0, 0, 0, 1));
        tbl.push_back(mk(0,  0,  0, 0,  0, 0, 0, 0, 0, 0, 0, 0, 1));

        reset = 1'b1; ID_Valid = 0; ID_Rs = 0; ID_Rt = 0; ID_UsesRt = 0;
        ID_WriteReg = 0; ID_RegWrite = 0; ID_MemRead = 0; Flush = 0;
        repeat (2) @(posedge clk);
        #1;
        model_reset();

        for (int i = 0; i < tbl.size(); i++) begin
            drive(0, tbl[i].v, tbl[i].rs, tbl[i].rt, tbl[i].ut, tbl[i].wr, tbl[i].rw,
                  tbl[i].mr, tbl[i].fl);
            model_check($sformatf("vec%0d", i));
            chk($sformatf("vec%0d tbl ForwardA", i), fa, tbl[i].fa);
            chk($sformatf("vec%0d tbl ForwardB", i), fb, tbl[i].fb);
            chk($sformatf("vec%0d tbl Stall", i), st, tbl[i].st);
            chk($sformatf("vec%0d tbl Bubble", i), bu, tbl[i].bu);
            chk($sformatf("vec%0d tbl StallCount", i), cnt, tbl[i].cnt);
            advance();
        end

        // Five load-use stalls saturate the 2-bit counter, then reset lands mid-stall.
        for (int p = 0; p < 6; p++) begin
            drive(0, 1, 1, 0, 0, 4, 1, 1, 0);
            model_check($sformatf("sat%0d lw", p));
            advance();
            drive(p == 5, 1, 4, 0, 0, 20, 1, 0, 0);
            model_check($sformatf("sat%0d use", p));
            chk($sformatf("sat%0d stall", p), st2, 1);
            if (p == 5) begin
                chk("sat held count(w2)", cnt2, 3);
                chk("sat count(w16)", cnt, 6);
            end
            advance();
        end
        drive(0, 1, 4, 4, 1, 20, 1, 0, 0);
        model_check("post-reset");
        chk("post-reset ForwardA", fa2, 0);
        chk("post-reset ForwardB", fb2, 0);
        chk("post-reset Stall", st2, 0);
        chk("post-reset StallCount(w2)", cnt2, 0);
        chk("post-reset StallCount(w16)", cnt, 0);
        advance();

        for (int k = 0; k < 400; k++) begin
            drive($urandom_range(0, 59) == 0, $urandom_range(0, 3) != 0,
                  $urandom_range(0, 7), $urandom_range(0, 7), 1'($urandom),
                  $urandom_range(0, 7), 1'($urandom), 1'($urandom),
                  $urandom_range(0, 7) == 0);
            model_check($sformatf("rnd%0d", k));
            advance();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
